map_symbol_scheduler: RTL and testbench

- Sequences one OFDM symbol through the subcarrier map ROM (2-bit code per bin, bandwidth slice chosen by index_bw, 1-cycle read latency).
- For each bin 0..FFTSIZE-1, reads the map code, pulls a data sample, inserts a pilot or zero, and emits an IFFT-ordered stream with valid/ready.
- Sits between the modulator data FIFO and the IFFT input buffer.

---
 rtl/map_symbol_scheduler.sv | 158 +++++++++++++++
 tb/tb_map_symbol_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/map_symbol_scheduler.sv
// rtl/map_symbol_scheduler.sv - walks one OFDM symbol through the subcarrier map and emits IFFT-ordered beats (optional MAP_SCHED_PILOT_PRBS_EN)
module map_symbol_scheduler #(
    parameter int                     DEPTH_RAM = 10,
    parameter int                     FFTSIZE   = 1024,
    parameter int                     DW        = 16,
    parameter int                     NUM_BW    = 6,
    parameter logic signed [DW-1:0]   PILOT_AMP = 16'sd5793
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sym_start,
    input  logic [2:0]             bw_sel,
    output logic                   busy,
    output logic                   sym_done,
    output logic                   bw_err,
    output logic [DEPTH_RAM-1:0]   rom_addr,
    output logic [2:0]             rom_index_bw,
    input  logic [1:0]             rom_dat,
    input  logic [DW-1:0]          din_i,
    input  logic [DW-1:0]          din_q,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic [DW-1:0]          dout_i,
    output logic [DW-1:0]          dout_q,
    output logic [1:0]             dout_type,
    output logic                   dout_sop,
    output logic                   dout_eop,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [DEPTH_RAM:0]     data_cnt
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    localparam logic [DEPTH_RAM-1:0] LAST_BIN = DEPTH_RAM'(FFTSIZE - 1);
    localparam logic [3:0]           NUM_BW_W = 4'(NUM_BW);

    state_t                 state;
    state_t                 state_nx;
    logic [DEPTH_RAM-1:0]   k;
    logic [2:0]             bw_q;
    logic [DEPTH_RAM:0]     cnt_q;
    logic [DEPTH_RAM:0]     data_cnt_q;
    logic                   bw_err_q;

    logic                   run;
    logic                   is_data;
    logic                   is_pilot;
    logic                   fire;
    logic                   last_bin;
    logic                   bw_ok;
    logic                   start_ok;
    logic [DW-1:0]          pilot_i;

`ifdef MAP_SCHED_PILOT_PRBS_EN
    logic [10:0]            lfsr;

    // Pilot sign sequence: x^11+x^9+1, reseeded every symbol, advanced per emitted pilot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= '1;
        end else if (start_ok) begin
            lfsr <= '1;
        end else if (fire && is_pilot) begin
            lfsr <= {lfsr[9:0], lfsr[10] ^ lfsr[8]};
        end
    end

    assign pilot_i = lfsr[10] ? -PILOT_AMP : PILOT_AMP;
`else
    assign pilot_i = PILOT_AMP;
`endif

    assign bw_ok    = ({1'b0, bw_sel} < NUM_BW_W);
    assign start_ok = (state == IDLE) && sym_start && bw_ok;
    assign run      = (state == RUN);
    assign is_data  = (rom_dat == 2'b01);
    assign is_pilot = (rom_dat == 2'b10);
    assign last_bin = (k == LAST_BIN);

    // Beat formation: data bins forward the FIFO handshake, pilot/null bins are always ready to go
    always_comb begin
        dout_valid = 1'b0;
        dout_i     = '0;
        dout_q     = '0;
        dout_type  = 2'b00;
        dout_sop   = 1'b0;
        dout_eop   = 1'b0;
        if (run) begin
            dout_valid = is_data ? din_valid : 1'b1;
            dout_type  = rom_dat;
            dout_sop   = (k == '0);
            dout_eop   = last_bin;
            if (is_data) begin
                dout_i = din_i;
                dout_q = din_q;
            end else if (is_pilot) begin
                dout_i = pilot_i;
            end
        end
    end

    assign fire      = dout_valid & dout_ready;
    assign din_ready = run & is_data & fire;

    // Look-ahead address so the ROM output for bin k+1 is ready the cycle after k fires
    assign rom_addr     = (fire && !last_bin) ? k + 1'b1 : k;
    assign rom_index_bw = bw_q;
    assign busy         = (state == PRIME) || run;
    assign sym_done     = (state == DONE);
    assign bw_err       = bw_err_q;
    assign data_cnt     = data_cnt_q;

    // Next-state decode for the symbol sequencer
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = PRIME;
            PRIME:   state_nx = RUN;
            RUN:     if (fire && last_bin) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Sequencer state, bin counter, slice latch and data-bin accounting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            bw_q       <= '0;
            cnt_q      <= '0;
            data_cnt_q <= '0;
            bw_err_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            bw_err_q <= (state == IDLE) && sym_start && !bw_ok;
            if (start_ok) begin
                k     <= '0;
                bw_q  <= bw_sel;
                cnt_q <= '0;
            end
            if (run && fire) begin
                if (!last_bin) begin
                    k <= k + 1'b1;
                end
                if (is_data) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (state == DONE) begin
                data_cnt_q <= cnt_q;
                k          <= '0;
            end
        end
    end

endmodule

// File: tb/tb_map_symbol_scheduler.sv
// tb/tb_map_symbol_scheduler.sv - randomized self-checking bench for map_symbol_scheduler
module tb_map_symbol_scheduler;

    localparam int N   = 1024;
    localparam int DW  = 16;
    localparam logic [15:0] AMP = 16'd5793;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            sym_start;
    logic [2:0]      bw_sel;
    logic            busy, sym_done, bw_err;
    logic [9:0]      rom_addr;
    logic [2:0]      rom_index_bw;
    logic [1:0]      rom_dat = 2'b00;
    logic [DW-1:0]   din_i, din_q;
    logic            din_valid, din_ready;
    logic [DW-1:0]   dout_i, dout_q;
    logic [1:0]      dout_type;
    logic            dout_sop, dout_eop, dout_valid, dout_ready;
    logic [10:0]     data_cnt;

    always #5 clk = ~clk;

    map_symbol_scheduler dut (
        .clk(clk), .rst_n(rst_n), .sym_start(sym_start), .bw_sel(bw_sel),
        .busy(busy), .sym_done(sym_done), .bw_err(bw_err),
        .rom_addr(rom_addr), .rom_index_bw(rom_index_bw), .rom_dat(rom_dat),
        .din_i(din_i), .din_q(din_q), .din_valid(din_valid), .din_ready(din_ready),
        .dout_i(dout_i), .dout_q(dout_q), .dout_type(dout_type),
        .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .data_cnt(data_cnt)
    );

    logic [1:0] rom_mem [0:8*N-1];

    // Map ROM with one cycle of read latency
    always @(posedge clk) rom_dat <= rom_mem[{rom_index_bw, rom_addr}];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rmode = 0;
    int vmode = 0;
    int pop_idx = 0;
    int cur_beat = 0;
    int starve_left = 0;
    int last_eop_cyc = 0;
    int prev_cnt = 0;
    logic rst_drv = 1'b0;
    logic [DW-1:0] di_arr [0:N-1];
    logic [DW-1:0] dq_arr [0:N-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic st, input logic [2:0] bs);
        @(negedge clk);
        rst_n      = rst_drv;
        sym_start  = st;
        bw_sel     = bs;
        dout_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        case (vmode)
            0:       din_valid = 1'b1;
            1:       din_valid = ($urandom_range(0, 3) != 0);
            default: din_valid = !(cur_beat == 1 && starve_left > 0);
        endcase
        din_i = di_arr[pop_idx % N];
        din_q = dq_arr[pop_idx % N];
        #1;
        cyc++;
    endtask

    task automatic run_symbol(input int bw, input int rm, input int vm, input bit poke_done,
                              input bit chk_lat, input bit b2b, input int mid_start, input int abort_at);
        int beat, didx, npulse, start_cyc, first_cyc, eop_cyc, starve_cnt, exp_cnt;
        bit done, prev_stall, fire, mid_sent;
        logic [1:0]  code;
        logic [10:0] lf;
        logic [35:0] vec, prev_vec, ev;
        logic [15:0] ei, eq;
        logic        st;
        logic [2:0]  bs;
        beat = 0; didx = 0; npulse = 0; first_cyc = -1; eop_cyc = 0; starve_cnt = 0;
        done = 0; prev_stall = 0; mid_sent = 0; lf = 11'h7FF; prev_vec = '0;
        exp_cnt = 0;
        for (int n = 0; n < N; n++) begin
            if (rom_mem[bw*N + n] == 2'b01) exp_cnt++;
            di_arr[n] = 16'($urandom);
            dq_arr[n] = 16'($urandom);
        end
        pop_idx = 0; rmode = rm; vmode = vm; starve_left = 10; cur_beat = 0;
        step(1'b1, 3'(bw));
        chk("data_cnt_hold", 64'(data_cnt), 64'(prev_cnt));
        chk("idle_quiet", {busy, dout_valid, din_ready}, 3'b000);
        start_cyc = cyc;
        for (int t = 0; t < 40000 && !done; t++) begin
            st = (mid_start >= 0 && beat == mid_start && !mid_sent);
            if (st) mid_sent = 1;
            bs = st ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
            cur_beat = beat;
            step(st, bs);
            code = rom_mem[bw*N + beat];
            fire = dout_valid && dout_ready;
            vec  = {dout_i, dout_q, dout_type, dout_sop, dout_eop};
            chk("busy", 64'(busy), 64'(1));
            chk("idx_bw", 64'(rom_index_bw), 64'(bw));
            chk("rom_addr", 64'(rom_addr), 64'(beat + ((fire && beat < N-1) ? 1 : 0)));
            chk("din_ready", 64'(din_ready), 64'(fire && code == 2'b01 && t > 0));
            if (prev_stall) chk("stall_stable", vec, prev_vec);
            if (vm == 2 && t > 0 && beat == 1 && !din_valid) begin
                starve_cnt++;
                starve_left--;
                chk("starve_valid", 64'(dout_valid), 64'(0));
            end
            if (din_ready) begin
                pop_idx++;
                npulse++;
            end
            if (fire) begin
                ei = 16'h0; eq = 16'h0;
                if (code == 2'b01) begin
                    ei = di_arr[didx]; eq = dq_arr[didx]; didx++;
                end else if (code == 2'b10) begin
`ifdef MAP_SCHED_PILOT_PRBS_EN
                    ei = lf[10] ? -AMP : AMP;
                    lf = {lf[9:0], lf[10] ^ lf[8]};
`else
                    ei = AMP;
`endif
                end
                ev = {ei, eq, code, beat == 0, beat == N-1};
                chk("beat", vec, ev);
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    if (chk_lat) chk("latency", 64'(first_cyc - start_cyc), 64'(2));
                    if (b2b) chk("eop_sop_gap", 64'(first_cyc - last_eop_cyc), 64'(4));
                end
                if (beat == N-1) begin
                    done = 1;
                    eop_cyc = cyc;
                end else begin
                    beat++;
                end
            end
            prev_stall = dout_valid && !dout_ready;
            prev_vec = vec;
            if (abort_at >= 0 && beat == abort_at) return;
        end
        if (!done) begin
            chk("symbol_timeout", 64'(0), 64'(1));
            return;
        end
        chk("din_pulses", 64'(npulse), 64'(exp_cnt));
        if (vm == 2) chk("starve_cycles", 64'(starve_cnt), 64'(10));
        step(poke_done, 3'd0);
        chk("done_pulse", {sym_done, busy, dout_valid}, 3'b100);
        last_eop_cyc = eop_cyc;
        prev_cnt = exp_cnt;
    endtask

    initial begin
        for (int b = 0; b < 8; b++)
            for (int n = 0; n < N; n++)
                rom_mem[b*N + n] = (b == 0) ? 2'b00 : 2'($urandom_range(0, 3));
        rom_mem[1] = 2'b01;
        rom_mem[2] = 2'b10;
        rom_mem[3] = 2'b01;
        for (int n = 0; n < N; n++) begin
            di_arr[n] = '0;
            dq_arr[n] = '0;
        end

        rst_drv = 1'b0;
        repeat (3) step(1'b1, 3'd1);
        chk("rst_ctrl", {busy, sym_done, bw_err, din_ready}, 4'b0000);
        chk("rst_dout", {dout_valid, dout_sop, dout_eop, dout_type, dout_i, dout_q}, 37'd0);
        chk("rst_rom", {rom_addr, rom_index_bw}, 13'd0);
        chk("rst_cnt", 64'(data_cnt), 64'(0));
        rst_drv = 1'b1;
        step(1'b0, 3'd0);

        // directed map, no back-pressure; start during DONE must be ignored
        run_symbol(0, 0, 0, 1'b1, 1'b1, 1'b0, -1, -1);
        step(1'b0, 3'd0);
        chk("done_start_ignored", {busy, dout_valid}, 2'b00);
        chk("data_cnt_directed", 64'(data_cnt), 64'(2));
        step(1'b0, 3'd0);
        chk("still_idle", 64'(busy), 64'(0));

        // random back-pressure, then a back-to-back symbol with bin 1 starved
        run_symbol(0, 1, 0, 1'b0, 1'b0, 1'b0, -1, -1);
        run_symbol(0, 0, 2, 1'b0, 1'b1, 1'b1, -1, -1);

        // rejected slices
        for (int b = 6; b < 8; b++) begin
            step(1'b1, 3'(b));
            step(1'b0, 3'd0);
            chk("bw_err_pulse", {bw_err, busy}, 2'b10);
            step(1'b0, 3'd0);
            chk("bw_err_clear", {bw_err, busy, dout_valid}, 3'b000);
        end

        run_symbol(5, 1, 1, 1'b0, 1'b0, 1'b0, -1, -1);

        // mid-symbol start ignored, then reset at bin 500
        run_symbol(3, 1, 1, 1'b0, 1'b0, 1'b0, 100, 500);
        rst_drv = 1'b0;
        step(1'b0, 3'd0);
        rst_drv = 1'b1;
        step(1'b0, 3'd0);
        chk("abort_ctrl", {busy, sym_done, bw_err, din_ready, dout_valid}, 5'b00000);
        chk("abort_rom", {rom_addr, rom_index_bw}, 13'd0);
        chk("abort_cnt", 64'(data_cnt), 64'(0));
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 3'd0);
            chk("abort_no_done", {sym_done, busy}, 2'b00);
        end
        prev_cnt = 0;

        run_symbol(1, 0, 0, 1'b0, 1'b1, 1'b0, -1, -1);
        run_symbol(2, 1, 1, 1'b0, 1'b0, 1'b0, -1, -1);
        step(1'b0, 3'd0);
        chk("data_cnt_final", 64'(data_cnt), 64'(prev_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
